// File: rtl/card_dealer.sv
// LFSR-driven dealer: writes five distinct, legal cards {suit, rank} to hand
// storage at addresses 0..4, one accepted candidate per cycle.
module card_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    output logic        we,
    output logic [2:0]  waddr,
    output logic [5:0]  card_out,
    output logic        busy,
    output logic        done,
    output logic [7:0]  reject_cnt
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_step;
    logic [2:0]  count;
    logic [5:0]  dealt [5];
    logic [5:0]  cand;
    logic        rank_ok;
    logic        dup;
    logic        accept;

    assign cand      = lfsr[5:0];
    assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign rank_ok   = (cand[3:0] >= 4'd2) && (cand[3:0] <= 4'd14);
    assign accept    = rank_ok && !dup;

    // Only cards already dealt into this hand (index < count) can collide.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        dup = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ((3'(i) < count) && (dealt[i] == cand)) begin
                dup = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!seed_load && start) state_nxt = DRAW;
            DRAW:    if (accept && (count == 3'd4)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= LFSR_SEED;
            count      <= 3'd0;
            we         <= 1'b0;
            waddr      <= 3'd0;
            card_out   <= 6'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            reject_cnt <= 8'd0;
            // NOTE: the dealt registers are five small flops, so they are reset
            // explicitly rather than treated as an uninitialised memory.
            for (int i = 0; i < 5; i++) begin
                dealt[i] <= 6'd0;
            end
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        lfsr <= (seed_in == 16'd0) ? LFSR_SEED : seed_in;
                    end else if (start) begin
                        count      <= 3'd0;
                        reject_cnt <= 8'd0;
                        busy       <= 1'b1;
                    end
                end
                DRAW: begin
                    lfsr <= lfsr_step;
                    if (accept) begin
                        we           <= 1'b1;
                        waddr        <= count;
                        card_out     <= cand;
                        dealt[count] <= cand;
                        count        <= count + 3'd1;
                    end else if (reject_cnt != 8'hFF) begin
                        reject_cnt <= reject_cnt + 8'd1;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: a reference LFSR/dealing model queues the
// expected writes per hand, and a negedge monitor pops and compares them.
module tb_card_dealer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        we;
    logic [2:0]  waddr;
    logic [5:0]  card_out;
    logic        busy;
    logic        done;
    logic [7:0]  reject_cnt;

    card_dealer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .we         (we),
        .waddr      (waddr),
        .card_out   (card_out),
        .busy       (busy),
        .done       (done),
        .reject_cnt (reject_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] addr;
        logic [5:0] card;
    } wr_t;

    wr_t         exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_lfsr;
    int          exp_rej;
    logic [5:0]  hand_cards [5];
    int          wr_cnt = 0;
    int          rej_first;

    // Downstream hand storage sharing the dealer's reset.
    logic [5:0]  hs_mem [5];
    logic [2:0]  hs_cnt;
    logic        hand_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_cnt    <= 3'd0;
            hand_full <= 1'b0;
            for (int i = 0; i < 5; i++) hs_mem[i] <= 6'd0;
        end else begin
            if (hand_full) hs_cnt <= 3'd0;
            if (we) begin
                if (waddr < 3'd5) hs_mem[waddr] <= card_out;
                hs_cnt <= hs_cnt + 3'd1;
            end
            hand_full <= we && (hs_cnt == 3'd4);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Deals one whole hand from m_lfsr and queues the expected writes.
    task automatic model_hand();
        logic [5:0] d [5];
        logic [5:0] c;
        logic       ok;
        wr_t        w;
        int         n   = 0;
        int         rej = 0;
        while (n < 5) begin
            c  = m_lfsr[5:0];
            ok = (c[3:0] >= 4'd2) && (c[3:0] <= 4'd14);
            for (int i = 0; i < n; i++) if (d[i] == c) ok = 1'b0;
            if (ok) begin
                d[n]   = c;
                w.addr = 3'(n);
                w.card = c;
                exp_q.push_back(w);
                n++;
            end else if (rej < 255) begin
                rej++;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
        exp_rej = rej;
    endtask

    always @(negedge clk) begin
        wr_t e;
        logic distinct;
        if (rst_n) begin
            if (we) begin
                check("we_done_excl", done, 1'b0);
                check("sb_nonempty", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("waddr", waddr, e.addr);
                    check("card", card_out, e.card);
                end
                check("rank_legal", (card_out[3:0] >= 4'd2) && (card_out[3:0] <= 4'd14), 1'b1);
                distinct = 1'b1;
                for (int i = 0; i < 5; i++)
                    if (i < wr_cnt && hand_cards[i] == card_out) distinct = 1'b0;
                check("distinct", distinct, 1'b1);
                if (wr_cnt < 5) begin
                    hand_cards[wr_cnt] = card_out;
                    if (wr_cnt == 0) rej_first = int'(reject_cnt);
                end
                wr_cnt++;
            end else if (!busy && !done) begin
                wr_cnt = 0;
            end
        end
    end

    task automatic launch(input bit do_seed, input logic [15:0] seed);
        if (do_seed) begin
            @(negedge clk);
            seed_load = 1'b1;
            seed_in   = seed;
            @(negedge clk);
            seed_load = 1'b0;
            m_lfsr    = (seed == 16'd0) ? 16'hACE1 : seed;
        end
        model_hand();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic run_hand(input bit do_seed, input logic [15:0] seed, input bit noisy);
        int cycles = 0;
        launch(do_seed, seed);
        for (int k = 0; k < 400; k++) begin
            if (done) break;
            if (busy) cycles++;
            if (noisy && (k % 3 == 1)) begin
                start     = 1'b1;
                seed_load = 1'b1;
                seed_in   = 16'($urandom);
            end else begin
                start     = 1'b0;
                seed_load = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        start     = 1'b0;
        seed_load = 1'b0;
        check("done_seen", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("we_at_done", we, 1'b0);
        check("writes", wr_cnt, 5);
        check("sb_empty", exp_q.size(), 0);
        check("reject_cnt", reject_cnt, exp_rej);
        check("busy_cycles", cycles, 6 + int'(reject_cnt));
        check("hand_full", hand_full, 1'b1);
        for (int i = 0; i < 5; i++) check("stored", hs_mem[i], hand_cards[i]);
        @(negedge clk);
        #1;
        check("done_pulse", done, 1'b0);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"}, we, 1'b0);
        check({tag, "_waddr"}, waddr, 3'd0);
        check({tag, "_card"}, card_out, 6'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_rej"}, reject_cnt, 8'd0);
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        start     = 1'b0;
        seed_load = 1'b0;
        seed_in   = 16'd0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n  = 1'b1;
        m_lfsr = 16'hACE1;

        // Default seed: 0x21 rejected, then 0x03 and 0x07.
        run_hand(1'b0, 16'd0, 1'b0);
        check("dflt_card0", hand_cards[0], 6'h03);
        check("dflt_card1", hand_cards[1], 6'h07);
        check("dflt_rej_first", rej_first, 1);

        // Zero seed substitutes the default seed.
        run_hand(1'b1, 16'd0, 1'b0);
        check("zseed_card0", hand_cards[0], 6'h03);
        check("zseed_card1", hand_cards[1], 6'h07);

        // start/seed_load toggled while dealing must not disturb the hand.
        run_hand(1'b1, 16'h1234, 1'b1);
        run_hand(1'b1, 16'hBEEF, 1'b1);

        // Reset after the second write abandons the hand.
        launch(1'b1, 16'h5A5A);
        for (k = 0; k < 200 && wr_cnt < 2; k++) begin
            @(negedge clk);
            #1;
        end
        check("midrst_reached", wr_cnt >= 2, 1'b1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        check("midrst_hand_full", hand_full, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        m_lfsr = 16'hACE1;
        run_hand(1'b0, 16'd0, 1'b0);
        check("post_rst_card0", hand_cards[0], 6'h03);
        check("post_rst_card1", hand_cards[1], 6'h07);

        for (int h = 0; h < 1000; h++) begin
            run_hand(1'b1, 16'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
